// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the MAC lane array.
//   - DEF_DATA_W / DEF_ACC_W : default operand and accumulator widths
//   - lane_lo()              : bit offset of a lane inside a packed bus
//   - sat_hi() / sat_lo()    : saturation bounds for a given accumulator width
//                              and signedness, returned in a 64-bit container
//                              (callers keep the low ACC_W bits)
package mac_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 16;
  localparam int SAT_BOUND_W = 64;

  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

  // Largest representable value: all ones (unsigned) or 0111..1 (signed).
  function automatic logic [SAT_BOUND_W-1:0] sat_hi(input int acc_w, input bit is_signed);
    logic [SAT_BOUND_W-1:0] r;
    r = '0;
    for (int b = 0; b < SAT_BOUND_W; b++) begin
      if (b < acc_w - (is_signed ? 1 : 0)) r[b] = 1'b1;
    end
    return r;
  endfunction

  // Smallest representable value: zero (unsigned) or 1000..0 (signed).
  function automatic logic [SAT_BOUND_W-1:0] sat_lo(input int acc_w, input bit is_signed);
    logic [SAT_BOUND_W-1:0] r;
    r = '0;
    if (is_signed) r[acc_w-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/mac_lane_array_lane.sv
// mac_lane: one lane of the MAC array.
//   Stage 1 registers data*weight plus valid/last; stage 2 accumulates, or on
//   last dumps acc+product into a held output register and clears the acc.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   adv             : global advance (in_ready); 0 freezes stage 1 and stage 2
//   data, weight    : lane operands
//   valid, last     : lane input valid / end-of-accumulation
//   out_ready       : consumer ready, pops the held result
//   out, out_valid  : held result and its valid
//   stall           : this lane cannot complete a dump this cycle
//   sat_flag        : sticky saturation flag (only when MAC_SAT_EN is defined)
// Optional feature macro: MAC_SAT_EN (saturating instead of wrapping arithmetic).
module mac_lane
  import mac_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              adv,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] weight,
  input  logic              valid,
  input  logic              last,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out,
  output logic              out_valid,
`ifdef MAC_SAT_EN
  output logic              sat_flag,
`endif
  output logic              stall
);

  localparam int PROD_W  = 2 * DATA_W;
  localparam int EXT_PAD = ACC_W + 1 - PROD_W;

`ifdef MAC_SAT_EN
  localparam logic [SAT_BOUND_W-1:0] SAT_HI_W = sat_hi(ACC_W, SIGNED != 0);
  localparam logic [SAT_BOUND_W-1:0] SAT_LO_W = sat_lo(ACC_W, SIGNED != 0);
  localparam logic [ACC_W-1:0]       SAT_HI   = SAT_HI_W[ACC_W-1:0];
  localparam logic [ACC_W-1:0]       SAT_LO   = SAT_LO_W[ACC_W-1:0];
`endif

  logic [PROD_W-1:0] a_x, b_x, prod_p0;
  logic [PROD_W-1:0] prod_p1_q, prod_p1_d;
  logic              vld_p1_q, vld_p1_d;
  logic              last_p1_q, last_p1_d;
  logic [ACC_W-1:0]  acc_p2_q, acc_p2_d;
  logic [ACC_W-1:0]  out_p2_q, out_p2_d;
  logic              out_vld_p2_q, out_vld_p2_d;
  logic [ACC_W:0]    prod_x, acc_x, sum_x;
  logic [ACC_W-1:0]  sum;
  logic              accumulate, dump, pop;
`ifdef MAC_SAT_EN
  logic              ovf;
  logic              acc_sat_q, acc_sat_d;
  logic              sat_flag_q, sat_flag_d;
`endif

  always_comb begin
    // Operands are widened to the product width first so a plain same-width
    // multiply yields the correct two's-complement product when SIGNED=1.
    a_x     = (SIGNED != 0) ? {{DATA_W{data[DATA_W-1]}}, data}
                            : {{DATA_W{1'b0}}, data};
    b_x     = (SIGNED != 0) ? {{DATA_W{weight[DATA_W-1]}}, weight}
                            : {{DATA_W{1'b0}}, weight};
    prod_p0 = a_x * b_x;

    // Sum is formed one bit wider than the accumulator so overflow is visible.
    prod_x = {{EXT_PAD{(SIGNED != 0) & prod_p1_q[PROD_W-1]}}, prod_p1_q};
    acc_x  = {(SIGNED != 0) & acc_p2_q[ACC_W-1], acc_p2_q};
    sum_x  = acc_x + prod_x;

`ifdef MAC_SAT_EN
    ovf = (SIGNED != 0) ? (sum_x[ACC_W] ^ sum_x[ACC_W-1]) : sum_x[ACC_W];
    if (ovf) begin
      // Signed: the true sign is the extra top bit.
      sum = ((SIGNED != 0) && sum_x[ACC_W]) ? SAT_LO : SAT_HI;
    end else begin
      sum = sum_x[ACC_W-1:0];
    end
`else
    sum = sum_x[ACC_W-1:0];
`endif

    accumulate = adv & vld_p1_q & ~last_p1_q;
    dump       = adv & vld_p1_q & last_p1_q;
    pop        = out_ready & out_vld_p2_q;

    // ---- stage 1: product register ----
    prod_p1_d = adv ? prod_p0 : prod_p1_q;
    vld_p1_d  = adv ? valid   : vld_p1_q;
    last_p1_d = adv ? last    : last_p1_q;

    // ---- stage 2: accumulator and held output ----
    acc_p2_d = acc_p2_q;
    if (dump)            acc_p2_d = '0;
    else if (accumulate) acc_p2_d = sum;

    out_p2_d     = dump ? sum : out_p2_q;
    // A dump on the pop edge reloads the output without a bubble.
    out_vld_p2_d = dump | (out_vld_p2_q & ~pop);

`ifdef MAC_SAT_EN
    acc_sat_d = acc_sat_q;
    if (dump)            acc_sat_d = 1'b0;
    else if (accumulate) acc_sat_d = acc_sat_q | ovf;
    sat_flag_d = (pop ? 1'b0 : sat_flag_q) | (dump & (acc_sat_q | ovf));
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prod_p1_q    <= '0;
      vld_p1_q     <= 1'b0;
      last_p1_q    <= 1'b0;
      acc_p2_q     <= '0;
      out_p2_q     <= '0;
      out_vld_p2_q <= 1'b0;
`ifdef MAC_SAT_EN
      acc_sat_q    <= 1'b0;
      sat_flag_q   <= 1'b0;
`endif
    end else begin
      prod_p1_q    <= prod_p1_d;
      vld_p1_q     <= vld_p1_d;
      last_p1_q    <= last_p1_d;
      acc_p2_q     <= acc_p2_d;
      out_p2_q     <= out_p2_d;
      out_vld_p2_q <= out_vld_p2_d;
`ifdef MAC_SAT_EN
      acc_sat_q    <= acc_sat_d;
      sat_flag_q   <= sat_flag_d;
`endif
    end
  end

  // A pending dump with an unpopped result blocks the whole array.
  assign stall     = vld_p1_q & last_p1_q & out_vld_p2_q & ~out_ready;
  assign out       = out_p2_q;
  assign out_valid = out_vld_p2_q;
`ifdef MAC_SAT_EN
  assign sat_flag  = sat_flag_q;
`endif

endmodule

// File: rtl/mac_lane_array.sv
// mac_lane_array: NUM_MACS independent multiply-accumulate lanes with a
// shared ready/valid backpressure path.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   datas, weights     : lane i operand at [i*DATA_W +: DATA_W]
//   valids, lasts      : per-lane valid / end-of-accumulation
//   in_ready           : inputs are accepted on an edge only when 1
//   outs               : lane i result at [i*ACC_W +: ACC_W]
//   outValids          : per-lane result held and valid
//   out_ready          : pops every lane with outValids=1
//   sat_flags          : per-lane sticky saturation flags (MAC_SAT_EN only)
// Optional feature macro: MAC_SAT_EN.
module mac_lane_array
  import mac_pkg::*;
#(
  parameter int NUM_MACS = 8,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int SIGNED   = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_MACS*DATA_W-1:0] datas,
  input  logic [NUM_MACS*DATA_W-1:0] weights,
  input  logic [NUM_MACS-1:0]        valids,
  input  logic [NUM_MACS-1:0]        lasts,
  output logic                       in_ready,
  output logic [NUM_MACS*ACC_W-1:0]  outs,
  output logic [NUM_MACS-1:0]        outValids,
`ifdef MAC_SAT_EN
  output logic [NUM_MACS-1:0]        sat_flags,
`endif
  input  logic                       out_ready
);

  logic [NUM_MACS-1:0] stall_vec;

  assign in_ready = ~(|stall_vec);

  for (genvar i = 0; i < NUM_MACS; i++) begin : g_lane
    mac_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .SIGNED (SIGNED)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .adv       (in_ready),
      .data      (datas[lane_lo(i, DATA_W) +: DATA_W]),
      .weight    (weights[lane_lo(i, DATA_W) +: DATA_W]),
      .valid     (valids[i]),
      .last      (lasts[i]),
      .out_ready (out_ready),
      .out       (outs[lane_lo(i, ACC_W) +: ACC_W]),
      .out_valid (outValids[i]),
`ifdef MAC_SAT_EN
      .sat_flag  (sat_flags[i]),
`endif
      .stall     (stall_vec[i])
    );
  end

endmodule

// File: tb/tb_mac_lane_array.sv
module tb_mac_lane_array;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int AW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N*DW-1:0] datas, weights;
  logic [N-1:0]    valids, lasts;
  logic            out_ready;
  logic            in_ready, in_ready_s;
  logic [N*AW-1:0] outs, outs_s;
  logic [N-1:0]    outValids, outValids_s;
`ifdef MAC_SAT_EN
  logic [N-1:0]    sat_flags, sat_flags_s;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_lane_array #(.NUM_MACS(N), .DATA_W(DW), .ACC_W(AW), .SIGNED(0)) u_dut (
    .clk(clk), .reset(reset), .datas(datas), .weights(weights),
    .valids(valids), .lasts(lasts), .in_ready(in_ready), .outs(outs),
    .outValids(outValids),
`ifdef MAC_SAT_EN
    .sat_flags(sat_flags),
`endif
    .out_ready(out_ready)
  );

  mac_lane_array #(.NUM_MACS(N), .DATA_W(DW), .ACC_W(AW), .SIGNED(1)) u_dut_s (
    .clk(clk), .reset(reset), .datas(datas), .weights(weights),
    .valids(valids), .lasts(lasts), .in_ready(in_ready_s), .outs(outs_s),
    .outValids(outValids_s),
`ifdef MAC_SAT_EN
    .sat_flags(sat_flags_s),
`endif
    .out_ready(out_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat on the selected lanes for one edge, then go idle.
  task automatic beat(input logic [7:0] d, input logic [7:0] w,
                      input logic [N-1:0] v, input logic [N-1:0] l);
    datas   = {N{d}};
    weights = {N{w}};
    valids  = v;
    lasts   = l;
    tick();
    valids  = '0;
    lasts   = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; datas = '0; weights = '0; valids = '0; lasts = '0; out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if (outs !== '0) begin $display("FAIL reset_outs got %h exp 0", outs); errors++; end
    checks++;
    if (outValids !== 8'h00) begin $display("FAIL reset_valids got %h exp 00", outValids); errors++; end
    checks++;
    if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready got %b exp 1", in_ready); errors++; end
  endtask

  task automatic test_all_lanes();
    out_ready = 1'b1;
    beat(8'h08, 8'h04, 8'hFF, 8'h00);
    beat(8'h02, 8'h03, 8'hFF, 8'h00);
    beat(8'h01, 8'h02, 8'hFF, 8'hFF);
    checks++;
    if (outValids !== 8'h00) begin $display("FAIL all_latency got %h exp 00", outValids); errors++; end
    tick();
    checks++;
    if (outValids !== 8'hFF) begin $display("FAIL all_valids got %h exp FF", outValids); errors++; end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (outs[i*AW +: AW] !== 16'h0028) begin
        $display("FAIL all_lane%0d got %h exp 0028", i, outs[i*AW +: AW]); errors++;
      end
    end
    tick();
    checks++;
    if (outValids !== 8'h00) begin $display("FAIL all_pop got %h exp 00", outValids); errors++; end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    beat(8'h03, 8'h05, 8'h01, 8'h01);           // lane 0 result 15
    tick();
    checks++;
    if (outValids !== 8'h01 || outs[0 +: AW] !== 16'h000F) begin
      $display("FAIL bp_first got v=%h o=%h exp v=01 o=000F", outValids, outs[0 +: AW]); errors++;
    end
    beat(8'h04, 8'h04, 8'h01, 8'h01);           // second result 16 waits in stage 1
    checks++;
    if (in_ready !== 1'b0) begin $display("FAIL bp_in_ready_drop got %b exp 0", in_ready); errors++; end
    // Held input that must not be captured while stalled.
    datas = {N{8'h02}}; weights = {N{8'h02}}; valids = 8'h01; lasts = 8'h00;
    tick(); tick();
    checks++;
    if (in_ready !== 1'b0 || outs[0 +: AW] !== 16'h000F) begin
      $display("FAIL bp_hold got r=%b o=%h exp r=0 o=000F", in_ready, outs[0 +: AW]); errors++;
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin $display("FAIL bp_release got %b exp 1", in_ready); errors++; end
    tick();                                      // pop 15, load 16, capture 2*2
    valids = 8'h00;
    checks++;
    if (outValids !== 8'h01 || outs[0 +: AW] !== 16'h0010) begin
      $display("FAIL bp_second got v=%h o=%h exp v=01 o=0010", outValids, outs[0 +: AW]); errors++;
    end
    beat(8'h01, 8'h01, 8'h01, 8'h01);
    tick();
    checks++;
    if (outValids !== 8'h01 || outs[0 +: AW] !== 16'h0005) begin
      $display("FAIL bp_third got v=%h o=%h exp v=01 o=0005", outValids, outs[0 +: AW]); errors++;
    end
    tick();
  endtask

  task automatic test_per_lane();
    out_ready = 1'b1;
    beat(8'h01, 8'h01, 8'hFE, 8'h00);           // lanes 1..7 hold acc=1
    beat(8'hFF, 8'hFF, 8'h01, 8'h01);
    tick();
    checks++;
    if (outValids !== 8'h01) begin $display("FAIL lane_valids got %h exp 01", outValids); errors++; end
    checks++;
    if (outs[0 +: AW] !== 16'hFE01) begin $display("FAIL lane0 got %h exp FE01", outs[0 +: AW]); errors++; end
    beat(8'h01, 8'h01, 8'hFE, 8'hFE);
    tick();
    checks++;
    if (outValids !== 8'hFE) begin $display("FAIL lane_rest_valids got %h exp FE", outValids); errors++; end
    for (int i = 1; i < N; i++) begin
      checks++;
      if (outs[i*AW +: AW] !== 16'h0002) begin
        $display("FAIL lane%0d_acc got %h exp 0002", i, outs[i*AW +: AW]); errors++;
      end
    end
    tick();
  endtask

  task automatic test_signed();
    out_ready = 1'b1;
    beat(8'hFE, 8'h03, 8'hFF, 8'hFF);
    tick();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (outs_s[i*AW +: AW] !== 16'hFFFA) begin
        $display("FAIL signed_lane%0d got %h exp FFFA", i, outs_s[i*AW +: AW]); errors++;
      end
    end
    checks++;
    if (outs[0 +: AW] !== 16'h02FA) begin $display("FAIL unsigned_fe3 got %h exp 02FA", outs[0 +: AW]); errors++; end
    tick();
  endtask

  task automatic test_overflow();
    logic [15:0] exp_v;
`ifdef MAC_SAT_EN
    exp_v = 16'hFFFF;
`else
    exp_v = 16'hFA03;
`endif
    out_ready = 1'b1;
    beat(8'hFF, 8'hFF, 8'hFF, 8'h00);
    beat(8'hFF, 8'hFF, 8'hFF, 8'h00);
    beat(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    tick();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (outs[i*AW +: AW] !== exp_v) begin
        $display("FAIL ovf_lane%0d got %h exp %h", i, outs[i*AW +: AW], exp_v); errors++;
      end
    end
`ifdef MAC_SAT_EN
    checks++;
    if (sat_flags !== 8'hFF) begin $display("FAIL sat_flags got %h exp FF", sat_flags); errors++; end
    tick();
    checks++;
    if (sat_flags !== 8'h00) begin $display("FAIL sat_flags_pop got %h exp 00", sat_flags); errors++; end
`else
    tick();
`endif
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    beat(8'h05, 8'h05, 8'hFF, 8'h00);
    beat(8'h05, 8'h05, 8'hFF, 8'h00);
    reset = 1'b1;
    beat(8'h07, 8'h07, 8'hFF, 8'hFF);           // ignored during reset
    reset = 1'b0;
    checks++;
    if (outValids !== 8'h00) begin $display("FAIL rst_mid_valids got %h exp 00", outValids); errors++; end
    beat(8'h02, 8'h03, 8'hFF, 8'hFF);
    tick();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (outs[i*AW +: AW] !== 16'h0006) begin
        $display("FAIL rst_mid_lane%0d got %h exp 0006", i, outs[i*AW +: AW]); errors++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_lanes();
    test_backpressure();
    test_per_lane();
    test_signed();
    test_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
